// File: rtl/cim_pkg.sv
// cim_pkg: shared widths, opcodes, field positions and FSM states for the CIM command issuer
package cim_pkg;
    localparam int Col_num_bit = 6;
    localparam int Row_num     = 16;
    localparam int INSTR_W     = 32;
    localparam int LDST_CMD_W  = Col_num_bit + 1;
    localparam int COMP_CMD_W  = 25;
    localparam int OP_HI       = 31;
    localparam int OP_LO       = 30;
    localparam int ST_BIT      = Col_num_bit;
    localparam int ST_DATA_LO  = LDST_CMD_W;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LDST = 2'b01,
        OP_COMP = 2'b10,
        OP_RSV  = 2'b11
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;
endpackage

// File: rtl/cim_cmd_issuer_if.sv
// cim_cmd_issuer_if: host instruction handshake plus CIM controller command/status signals
interface cim_cmd_issuer_if #(parameter int ROW_NUM = cim_pkg::Row_num);
    import cim_pkg::*;
    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    in_instr;
    logic                  ExLdSt_valid;
    logic [LDST_CMD_W-1:0] ExLdSt_command;
    logic                  Compute_valid;
    logic                  Compute_ready;
    logic [COMP_CMD_W-1:0] Compute_command;
    logic                  rd_valid;
    logic [ROW_NUM-1:0]    rd_data;
    logic                  busy;
    logic                  err;
    logic [15:0]           retired;

    modport master (
        output in_valid, in_instr, Compute_ready,
        input  in_ready, ExLdSt_valid, ExLdSt_command, Compute_valid, Compute_command,
               rd_valid, rd_data, busy, err, retired
    );

    modport slave (
        input  in_valid, in_instr, Compute_ready,
        output in_ready, ExLdSt_valid, ExLdSt_command, Compute_valid, Compute_command,
               rd_valid, rd_data, busy, err, retired
    );
endinterface

// File: rtl/cim_cmd_fifo.sv
// cim_cmd_fifo: synchronous instruction queue with registered full/empty and no read bypass
module cim_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q, wptr_d, rptr_d;
    logic         full_q, empty_q, do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;
    assign wptr_d  = wptr_q + (AW+1)'(do_push);
    assign rptr_d  = rptr_q + (AW+1)'(do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Pointers carry a wrap bit so flags can be registered from the next-state pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty_q <= wptr_d == rptr_d;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/cim_cmd_issuer.sv
// cim_cmd_issuer: queues host instructions and issues load/store and compute commands to the CIM controller
module cim_cmd_issuer
    import cim_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_NUM    = Row_num
) (
    input  logic                clk,
    input  logic                rst,
    cim_cmd_issuer_if.slave     bus,
    inout  wire [ROW_NUM-1:0]   ExLdSt_data
);
    state_e             state_q, state_d;
    logic [INSTR_W-1:0] cur_q, cur_d, head;
    logic               empty, full, pop, done, exec, ldst_v, comp_v, load_v;
    opcode_e            op;
    logic               rd_valid_q, err_q;
    logic [ROW_NUM-1:0] rd_data_q;
    logic [15:0]        retired_q;

    cim_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid & ~full),
        .pop_i   (pop),
        .wdata_i (bus.in_instr),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign op     = opcode_e'(cur_q[OP_HI:OP_LO]);
    assign exec   = state_q == EXEC;
    assign ldst_v = exec && op == OP_LDST;
    assign comp_v = exec && op == OP_COMP;
    assign load_v = ldst_v && !cur_q[ST_BIT];

    // Completion, pop and next state: compute waits for ready, everything else finishes in one cycle
    always_comb begin
        done    = exec && (op != OP_COMP || bus.Compute_ready);
        pop     = !empty && (!exec || done);
        state_d = pop ? EXEC : (done ? IDLE : state_q);
        cur_d   = pop ? head : cur_q;
    end

    // State and current-instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Load return capture, sticky reserved-opcode flag and retirement counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            retired_q  <= '0;
        end else begin
            rd_valid_q <= load_v;
            if (load_v) rd_data_q <= ExLdSt_data;
            err_q      <= err_q | (exec && op == OP_RSV);
            retired_q  <= retired_q + 16'(done);
        end
    end

    assign ExLdSt_data         = (ldst_v && cur_q[ST_BIT]) ? cur_q[ST_DATA_LO +: ROW_NUM] : 'z;
    assign bus.ExLdSt_valid    = ldst_v;
    assign bus.ExLdSt_command  = ldst_v ? cur_q[LDST_CMD_W-1:0] : '0;
    assign bus.Compute_valid   = comp_v;
    assign bus.Compute_command = comp_v ? cur_q[COMP_CMD_W-1:0] : '0;
    assign bus.in_ready        = ~full;
    assign bus.busy            = ~empty | exec;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_data         = rd_data_q;
    assign bus.err             = err_q;
    assign bus.retired         = retired_q;
endmodule

// File: tb/tb_cim_cmd_issuer.sv
// tb_cim_cmd_issuer: directed vector table plus back-to-back, full-queue and mid-compute reset sequences
module tb_cim_cmd_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [15:0] ex_data;
    int          checks = 0;
    int          errors = 0;
    int          exp_ret = 0;

    cim_cmd_issuer_if #(.ROW_NUM(16)) bus ();

    cim_cmd_issuer #(.FIFO_DEPTH(4), .ROW_NUM(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ExLdSt_data (ex_data)
    );

    always #5 clk = ~clk;

    // Controller model: answers a load strobe with a fixed data word
    assign ex_data = (bus.ExLdSt_valid && !bus.ExLdSt_command[6]) ? 16'hBEEF : 16'hzzzz;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic        ldst;
        logic [6:0]  cmd;
        logic [15:0] sdata;
        logic        comp;
        logic [24:0] ccmd;
        logic        rd;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_hz(input string name);
        checks++;
        if (!((ex_data === 16'h0) || $isunknown(ex_data))) begin
            errors++;
            $display("FAIL %s bus driven %h expected high-Z", name, ex_data);
        end
    endtask

    initial begin
        int n;
        logic [15:0] d;
        vecs[0] = '{32'h4000_0F6A, 0, 1'b1, 7'h6A, 16'h001E, 1'b0, 25'h0,       1'b0, 1'b0};
        vecs[1] = '{32'h4000_0005, 0, 1'b1, 7'h05, 16'h0000, 1'b0, 25'h0,       1'b1, 1'b0};
        vecs[2] = '{32'h80E8_A1C3, 7, 1'b0, 7'h00, 16'h0000, 1'b1, 25'h0E8A1C3, 1'b0, 1'b0};
        vecs[3] = '{32'h8100_0001, 0, 1'b0, 7'h00, 16'h0000, 1'b1, 25'h1000001, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0000, 0, 1'b0, 7'h00, 16'h0000, 1'b0, 25'h0,       1'b0, 1'b0};
        vecs[5] = '{32'h407F_FFFF, 0, 1'b1, 7'h7F, 16'hFFFF, 1'b0, 25'h0,       1'b0, 1'b0};
        vecs[6] = '{32'h4000_003F, 0, 1'b1, 7'h3F, 16'h0000, 1'b0, 25'h0,       1'b1, 1'b0};
        vecs[7] = '{32'hC000_0000, 0, 1'b0, 7'h00, 16'h0000, 1'b0, 25'h0,       1'b0, 1'b1};
        vecs[8] = '{32'h0000_ABCD, 0, 1'b0, 7'h00, 16'h0000, 1'b0, 25'h0,       1'b0, 1'b1};
        bus.in_valid      = 1'b0;
        bus.in_instr      = '0;
        bus.Compute_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_valids", {bus.ExLdSt_valid, bus.Compute_valid, bus.rd_valid}, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_comp_cmd", bus.Compute_command, 0);
        chk("rst_busy", bus.busy, 0);
        chk_hz("rst_bus");
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.in_valid      = 1'b1;
            bus.in_instr      = vecs[i].instr;
            bus.Compute_ready = vecs[i].stall == 0;
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("idle_strobes", {bus.ExLdSt_valid, bus.Compute_valid}, 0);
            chk("idle_busy", bus.busy, 1);
            chk_hz("idle_bus");
            @(negedge clk);
            chk("ldst_valid", bus.ExLdSt_valid, vecs[i].ldst);
            chk("comp_valid", bus.Compute_valid, vecs[i].comp);
            if (vecs[i].ldst) chk("ldst_cmd", bus.ExLdSt_command, vecs[i].cmd);
            if (vecs[i].ldst && vecs[i].cmd[6]) chk("st_data", ex_data, vecs[i].sdata);
            if (vecs[i].comp) chk("comp_cmd", bus.Compute_command, vecs[i].ccmd);
            for (int s = 1; s <= vecs[i].stall; s++) begin
                @(negedge clk);
                chk("stall_valid", bus.Compute_valid, 1);
                chk("stall_cmd", bus.Compute_command, vecs[i].ccmd);
                if (s == vecs[i].stall) bus.Compute_ready = 1'b1;
            end
            exp_ret++;
            @(negedge clk);
            chk("post_strobes", {bus.ExLdSt_valid, bus.Compute_valid}, 0);
            chk("post_rd_valid", bus.rd_valid, vecs[i].rd);
            if (vecs[i].rd) chk("post_rd_data", bus.rd_data, 16'hBEEF);
            chk("post_retired", bus.retired, 16'(exp_ret));
            chk("post_err", bus.err, vecs[i].err);
            chk("post_busy", bus.busy, 0);
            chk_hz("post_bus");
            @(negedge clk);
            chk("rd_pulse_end", bus.rd_valid, 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                d = 16'h1000 + 16'(k - 2);
                chk("b2b_valid", bus.ExLdSt_valid, 1);
                chk("b2b_cmd", bus.ExLdSt_command, 7'h40 | 7'(k - 2));
                chk("b2b_data", ex_data, d);
            end
            chk("b2b_ready", bus.in_ready, 1);
            d = 16'h1000 + 16'(k);
            bus.in_valid = 1'b1;
            bus.in_instr = {2'b01, 7'b0, d, 7'h40 | 7'(k)};
        end
        for (int j = 3; j < 5; j++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            d = 16'h1000 + 16'(j);
            chk("b2b_valid", bus.ExLdSt_valid, 1);
            chk("b2b_cmd", bus.ExLdSt_command, 7'h40 | 7'(j));
            chk("b2b_data", ex_data, d);
        end
        exp_ret += 5;
        @(negedge clk);
        chk("b2b_end_valid", bus.ExLdSt_valid, 0);
        chk("b2b_retired", bus.retired, 16'(exp_ret));
        bus.Compute_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) chk("full_in_ready", bus.in_ready, 0);
            bus.in_valid = 1'b1;
            bus.in_instr = (k == 0) ? 32'h8000_1234 : 32'h4000_0000 | 32'(k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_comp_valid", bus.Compute_valid, 1);
        chk("full_comp_cmd", bus.Compute_command, 25'h0001234);
        bus.Compute_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ExLdSt_valid) begin
                chk("full_col", bus.ExLdSt_command, 7'(n + 1));
                n++;
            end
        end
        exp_ret += 5;
        chk("full_strobes", n, 4);
        chk("full_retired", bus.retired, 16'(exp_ret));
        chk("full_drain_busy", bus.busy, 0);
        chk("full_drain_ready", bus.in_ready, 1);
        bus.Compute_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_instr = (k == 0) ? 32'h8000_0777 : 32'h4000_0F40 | 32'(k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst_comp_valid", bus.Compute_valid, 1);
        chk("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_comp_valid", bus.Compute_valid, 0);
        chk("rst_async_comp_cmd", bus.Compute_command, 0);
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_ready", bus.in_ready, 1);
        chk("rst_async_retired", bus.retired, 0);
        chk("rst_async_err", bus.err, 0);
        chk("rst_async_rd", {bus.rd_valid, bus.rd_data}, 0);
        chk_hz("rst_async_bus");
        @(negedge clk);
        rst = 1'b0;
        bus.Compute_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ExLdSt_valid || bus.Compute_valid) n++;
        end
        chk("post_rst_issues", n, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_retired", bus.retired, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
